// File: rtl/seq_detect_param_if.sv
// Bundle of stream, configuration and result signals for the parametrised
// serial pattern detector.
interface seq_detect_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               in_valid;
  logic               in_bit;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               clear_count;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               armed;

  modport master (
    output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clear_count,
    input  match, match_count, armed
  );

  modport slave (
    input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clear_count,
    output match, match_count, armed
  );
endinterface

// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime-loadable pattern/length, overlap or
// non-overlap detection and a saturating match counter.
module seq_detect_param #(
  parameter int                 MAX_LEN       = 8,
  parameter int                 CNT_W         = 8,
  parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(8'b0001_0110),
  parameter int                 RESET_LEN     = 5,
  parameter logic               RESET_OVERLAP = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  seq_detect_param_if.slave    bus
);
  localparam int               LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0)                 return LEN_W'(1);
    else if (int'(l) > MAX_LEN)  return LEN_W'(MAX_LEN);
    else                         return l;
  endfunction

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W:0]     fill_inc;
  logic               window_eq;
  logic               hit;

  // The incoming bit is compared together with the stored history, so a hit
  // is flagged on the same edge that accepts the final pattern bit.
  assign accept     = bus.in_valid & ~bus.cfg_load;
  assign hist_shift = {hist_q[MAX_LEN-2:0], bus.in_bit};
  assign fill_inc   = {1'b0, fill_q} + (LEN_W+1)'(1);
  assign window_eq  = ((hist_shift ^ pat_q) & len_mask(len_q)) == '0;
  assign hit        = accept && (fill_inc >= {1'b0, len_q}) && window_eq;

  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
    if (bus.cfg_load) begin
      pat_d  = bus.cfg_pattern;
      len_d  = clamp_len(bus.cfg_len);
      ovl_d  = bus.cfg_overlap;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else begin
      if (accept) begin
        hist_d = hist_shift;
        if (hit) begin
          match_d = 1'b1;
          // Non-overlap restarts the fill so no history bit serves two matches.
          fill_d  = ovl_q ? len_q : '0;
        end else if (fill_inc >= {1'b0, len_q}) begin
          fill_d = len_q;
        end else begin
          fill_d = fill_inc[LEN_W-1:0];
        end
      end
      if (bus.clear_count)             cnt_d = hit ? CNT_W'(1) : '0;
      else if (hit && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pat_q   <= RESET_PATTERN;
      len_q   <= LEN_W'(RESET_LEN);
      ovl_q   <= RESET_OVERLAP;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.match       = match_q;
  assign bus.match_count = cnt_q;
  assign bus.armed       = (fill_q >= len_q);
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed-vector bench for seq_detect_param: a driver queues hand-computed
// expectations per cycle and a negedge monitor pops and compares them.
module tb_seq_detect_param;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;

  typedef struct {
    logic  m;
    int    c;
    logic  a;
    string tag;
  } exp_t;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  seq_detect_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.match !== e.m || int'(bus.match_count) != e.c || bus.armed !== e.a) begin
        errors++;
        $display("FAIL %s: got match=%0b count=%0d armed=%0b, expected match=%0b count=%0d armed=%0b",
                 e.tag, bus.match, bus.match_count, bus.armed, e.m, e.c, e.a);
      end
    end
  end

  task automatic step(input logic v, input logic b, input logic ld, input logic clr,
                      input logic em, input int ec, input logic ea, input string tag);
    exp_t e;
    bus.in_valid    = v;
    bus.in_bit      = b;
    bus.cfg_load    = ld;
    bus.clear_count = clr;
    @(posedge clock);
    e.m = em; e.c = ec; e.a = ea; e.tag = tag;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic v, input logic b, input string tag);
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    bus.cfg_overlap = o;
    step(v, b, 1'b1, 1'b0, 1'b0, 0, 1'b0, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] bits;
    logic       last;
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_bit      = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;
    bus.clear_count = 1'b0;

    step(1, 1, 0, 0, 0, 0, 0, "reset_0");
    step(1, 0, 0, 0, 0, 0, 0, "reset_1");
    reset = 1'b0;

    // Reset pattern 10110, len 5, overlap
    step(1, 1, 0, 0, 0, 0, 0, "dflt_b1");
    step(1, 0, 0, 0, 0, 0, 0, "dflt_b2");
    step(1, 1, 0, 0, 0, 0, 0, "dflt_b3");
    step(1, 1, 0, 0, 0, 0, 0, "dflt_b4");
    step(1, 0, 0, 0, 1, 1, 1, "dflt_b5");
    step(0, 0, 0, 0, 0, 1, 1, "dflt_idle");

    // 101 overlap
    load(8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b0, "ovl_load");
    step(1, 1, 0, 0, 0, 0, 0, "ovl_b1");
    step(1, 0, 0, 0, 0, 0, 0, "ovl_b2");
    step(1, 1, 0, 0, 1, 1, 1, "ovl_b3");
    step(1, 0, 0, 0, 0, 1, 1, "ovl_b4");
    step(1, 1, 0, 0, 1, 2, 1, "ovl_b5");
    step(0, 0, 0, 0, 0, 2, 1, "ovl_idle");

    // 101 non-overlap; upper pattern bits set to confirm they are ignored
    load(8'b1110_0101, 4'd3, 1'b0, 1'b0, 1'b0, "novl_load");
    step(1, 1, 0, 0, 0, 0, 0, "novl_b1");
    step(1, 0, 0, 0, 0, 0, 0, "novl_b2");
    step(1, 1, 0, 0, 1, 1, 0, "novl_b3");
    step(1, 0, 0, 0, 0, 1, 0, "novl_b4");
    step(1, 1, 0, 0, 0, 1, 0, "novl_b5");
    step(0, 0, 0, 0, 0, 1, 0, "novl_idle");

    // Gapped input, idle cycle after every bit
    load(8'b0001_0110, 4'd5, 1'b1, 1'b0, 1'b0, "gap_load");
    bits = 5'b10110;
    for (int i = 0; i < 5; i++) begin
      last = (i == 4);
      step(1, bits[4-i], 0, 0, last, last ? 1 : 0, last, "gap_bit");
      step(0, 0, 0, 0, 0, last ? 1 : 0, last, "gap_idle");
    end

    // Load mid-stream discards the colliding bit
    step(1, 1, 0, 0, 0, 1, 1, "mid_b1");
    step(1, 0, 0, 0, 0, 1, 1, "mid_b2");
    step(1, 1, 0, 0, 0, 1, 1, "mid_b3");
    step(1, 1, 0, 0, 0, 1, 1, "mid_b4");
    load(8'b0001_0110, 4'd5, 1'b1, 1'b1, 1'b0, "mid_load");
    step(1, 1, 0, 0, 0, 0, 0, "mid_p1");
    step(1, 0, 0, 0, 0, 0, 0, "mid_p2");
    step(1, 1, 0, 0, 0, 0, 0, "mid_p3");
    step(1, 1, 0, 0, 0, 0, 0, "mid_p4");
    step(1, 0, 0, 0, 1, 1, 1, "mid_p5");

    // Saturating counter with pattern 11 on a run of ones; len 0 clamps to 1
    load(8'b0000_0001, 4'd0, 1'b1, 1'b0, 1'b0, "clamp_load");
    step(1, 0, 0, 0, 0, 0, 1, "clamp_b0");
    step(1, 1, 0, 0, 1, 1, 1, "clamp_b1");
    load(8'b0000_0011, 4'd2, 1'b1, 1'b0, 1'b0, "cnt_load");
    step(1, 1, 0, 0, 0, 0, 0, "cnt_b1");
    for (int i = 1; i <= 5; i++)
      step(1, 1, 0, 0, 1, (i < 3) ? i : 3, 1, "cnt_hit");
    step(1, 1, 0, 1, 1, 1, 1, "cnt_clr_hit");
    step(0, 0, 0, 1, 0, 0, 1, "cnt_clr_idle");

    // Length above MAX_LEN clamps to MAX_LEN: eight ones needed
    load(8'b1111_1111, 4'd12, 1'b1, 1'b0, 1'b0, "big_load");
    for (int i = 1; i <= 8; i++)
      step(1, 1, 0, 0, (i == 8), (i == 8) ? 1 : 0, (i == 8), "big_bit");

    // Asynchronous reset between edges after 1,0,1,1
    load(8'b0001_0110, 4'd5, 1'b1, 1'b0, 1'b0, "ar_load");
    step(1, 1, 0, 0, 0, 0, 0, "ar_b1");
    step(1, 0, 0, 0, 0, 0, 0, "ar_b2");
    step(1, 1, 0, 0, 0, 0, 0, "ar_b3");
    step(1, 1, 0, 0, 0, 0, 0, "ar_b4");
    step(1, 0, 0, 0, 1, 1, 1, "ar_b5");
    step(1, 1, 0, 0, 0, 1, 1, "ar_c1");
    step(1, 0, 0, 0, 0, 1, 1, "ar_c2");
    step(1, 1, 0, 0, 0, 1, 1, "ar_c3");
    step(1, 1, 0, 0, 0, 0, 0, "ar_c4_reset");
    #2 reset = 1'b1;
    #4 reset = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0, "ar_after");
    step(0, 0, 0, 0, 0, 0, 0, "ar_idle");

    repeat (3) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector, the successor of the fixed-pattern 10110 FSM detector. It watches a qualified one-bit input stream and pulses `match` when the most recent `len` accepted bits equal a runtime-loadable pattern. Overlap and non-overlap detection modes are selectable, and matches are accumulated in a saturating counter. It sits between a serial data source and control logic that needs sync-word or marker detection.

## Interface
- `MAX_LEN`, default 8: maximum pattern length in bits, ≥2.
- `CNT_W`, default 8: width of the match counter.
- `RESET_PATTERN`, default 8'b0001_0110: pattern loaded at reset, `MAX_LEN` bits wide.
- `RESET_LEN`, default 5: pattern length at reset.
- `RESET_OVERLAP`, default 1: detection mode at reset.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: `in_bit` is accepted on this edge.
- `in_bit` in 1: serial data bit.
- `cfg_load` in 1: capture `cfg_pattern`, `cfg_len` and `cfg_overlap` on this edge.
- `cfg_pattern` in MAX_LEN: pattern. Bit `len-1` is the oldest bit and bit 0 the newest. Bits at `len` and above are ignored.
- `cfg_len` in $clog2(MAX_LEN+1): pattern length.
- `cfg_overlap` in 1: 1 selects overlap mode, 0 selects non-overlap mode.
- `clear_count` in 1: synchronous clear of `match_count`.
- `match` out 1: registered one-cycle pulse per detection.
- `match_count` out CNT_W: saturating number of detections.
- `armed` out 1: the history holds at least `len` accepted bits since the last restart.

## Operation
- **Internal state:**
  - `pat`: active pattern.
  - `len`: active length.
  - `ovl`: active mode.
  - `hist`: MAX_LEN-bit shift register, newest bit in bit 0.
  - `fill`: count of accepted bits since the last restart, saturating at `len`.
- **Length clamping on load:** `cfg_len` = 0 stores 1. `cfg_len` > MAX_LEN stores MAX_LEN.
- **Accepted bit** (`in_valid`=1 and `cfg_load`=0):
  - `hist` shifts left with `in_bit` entering at bit 0.
  - Candidate window `w` = the low `len` bits of {`hist`, `in_bit`}.
  - A hit occurs when `fill`+1 ≥ `len` and `w` equals the low `len` bits of `pat`.
  - On a hit, `match` <= 1.
  - On a hit in overlap mode, `fill` saturates at `len`.
  - On a hit in non-overlap mode, `fill` <= 0. History bits may still shift, but they cannot be reused because `fill` restarts.
  - Without a hit, `fill` <= min(`fill`+1, `len`).
- **No accepted bit:** `match` <= 0, and `hist` and `fill` hold.
- **`cfg_load` has priority over `in_valid`:**
  - The current bit is discarded.
  - `pat`, `len` and `ovl` are updated.
  - `hist` <= 0, `fill` <= 0, `match` <= 0, `match_count` <= 0.
- **`match_count`:**
  - Increments on every hit and saturates at 2^CNT_W−1.
  - `clear_count` alone sets it to 0.
  - `clear_count` together with a hit sets it to 1; the new hit is counted.
- **`armed`** = (`fill` ≥ `len`), registered through `fill`.
- **Reset values:**
  - `match`=0, `match_count`=0, `armed`=0.
  - `hist`=0, `fill`=0.
  - `pat`=RESET_PATTERN, `len`=RESET_LEN, `ovl`=RESET_OVERLAP.
- **Reset mid-stream:** discards the partial history. No `match` is produced for bits straddling the reset.

## Timing
- **Latency:** `match` rises on the same edge that accepts the final pattern bit, is visible for the following cycle, and is exactly one cycle wide.
- **Back-to-back matches:** possible in overlap mode with a periodic pattern, e.g. 11 on the stream 111 gives pulses on consecutive accepted bits.
- **Gaps:** `in_valid` gaps of any length are transparent. `match` is low during the gap cycles.
- **Configuration timing:** a load takes effect for the bit accepted on the next edge after `cfg_load`.
- **`armed`** changes on the same edge as `fill`.

## Test plan
- **Reset defaults:** stream 1,0,1,1,0 with `in_valid`=1 every cycle -> `match` high one cycle after the 5th edge, `match_count`=1, `armed`=1.
- **Overlap mode:** load 101, len 3, overlap=1, stream 1,0,1,0,1 -> `match` after bits 3 and 5, `match_count`=2. Repeat with overlap=0 -> `match` only after bit 3, `match_count`=1.
- **Gapped input:** stream 1,0,1,1,0 with idle cycles between every bit -> a single `match` after the last accepted bit, and `match` low in every gap cycle.
- **Load mid-stream:** after 1,0,1,1, assert `cfg_load` with `in_valid`=1 and `in_bit`=0 -> no `match`, `fill`=0, `match_count`=0. A following full pattern matches normally.
- **Counter behaviour:** with CNT_W=2, run 5 overlapping hits -> count saturates at 3. Then assert `clear_count` on a hit cycle -> count=1.
- **Asynchronous reset:** pulse `reset` between edges after 1,0,1,1 -> outputs clear immediately. Sending 0 afterwards gives no `match`.
